// File: rtl/mips_defs.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : mips_defs                                                   |
// | Brief    : Opcodes, state encoding and mux-select codes shared by the  |
// |            multi-cycle controller and the datapath muxes.              |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package mips_defs;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_ORI   = 6'h0D;
    localparam logic [5:0] C_OP_LUI   = 6'h0F;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    localparam logic [5:0] C_FN_JR    = 6'h08;
    localparam logic [5:0] C_FN_ADDU  = 6'h21;
    localparam logic [5:0] C_FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_e;

    localparam logic [2:0] C_ALU_ADD    = 3'd0;
    localparam logic [2:0] C_ALU_SUB    = 3'd1;
    localparam logic [2:0] C_ALU_OR     = 3'd2;
    localparam logic [2:0] C_ALU_PASS_B = 3'd3;

    localparam logic [1:0] C_EXT_ZERO   = 2'd0;
    localparam logic [1:0] C_EXT_SIGN   = 2'd1;
    localparam logic [1:0] C_EXT_LUI    = 2'd2;

    localparam logic [1:0] C_RDST_RT    = 2'd0;
    localparam logic [1:0] C_RDST_RD    = 2'd1;
    localparam logic [1:0] C_RDST_RA    = 2'd2;

    localparam logic [1:0] C_WD_ALU     = 2'd0;
    localparam logic [1:0] C_WD_DM      = 2'd1;
    localparam logic [1:0] C_WD_PC4     = 2'd2;

    localparam logic [1:0] C_NPC_PC4    = 2'd0;
    localparam logic [1:0] C_NPC_BRANCH = 2'd1;
    localparam logic [1:0] C_NPC_JUMP   = 2'd2;
    localparam logic [1:0] C_NPC_RS     = 2'd3;

    typedef enum logic [3:0] {
        CLS_NOP    = 4'd0,
        CLS_ALU_R  = 4'd1,
        CLS_ALU_I  = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JUMP   = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JR     = 4'd8
    } instr_cls_e;

    // Static per-instruction information; ALU fields are only consumed in EXECUTE.
    typedef struct packed {
        instr_cls_e cls;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       alu_src_b;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/mips_mc_decode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mips_mc_decode                                              |
// | Brief    : Combinational opcode/funct classifier with ALU selects.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module mips_mc_decode
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec.cls       = CLS_NOP;
        dec.alu_op    = C_ALU_ADD;
        dec.ext_op    = C_EXT_ZERO;
        dec.alu_src_b = 1'b0;
        case (opcode)
            C_OP_RTYPE: begin
                case (funct)
                    C_FN_ADDU: dec.cls = CLS_ALU_R;
                    C_FN_SUBU: begin
                        dec.cls    = CLS_ALU_R;
                        dec.alu_op = C_ALU_SUB;
                    end
                    C_FN_JR:   dec.cls = CLS_JR;
                    default:   dec.cls = CLS_NOP;
                endcase
            end
            C_OP_ORI: begin
                dec.cls       = CLS_ALU_I;
                dec.alu_op    = C_ALU_OR;
                dec.ext_op    = C_EXT_ZERO;
                dec.alu_src_b = 1'b1;
            end
            C_OP_LUI: begin
                dec.cls       = CLS_ALU_I;
                dec.alu_op    = C_ALU_PASS_B;
                dec.ext_op    = C_EXT_LUI;
                dec.alu_src_b = 1'b1;
            end
            C_OP_LW: begin
                dec.cls       = CLS_LOAD;
                dec.ext_op    = C_EXT_SIGN;
                dec.alu_src_b = 1'b1;
            end
            C_OP_SW: begin
                dec.cls       = CLS_STORE;
                dec.ext_op    = C_EXT_SIGN;
                dec.alu_src_b = 1'b1;
            end
            C_OP_BEQ: begin
                dec.cls    = CLS_BRANCH;
                dec.alu_op = C_ALU_SUB;
            end
            C_OP_J:   dec.cls = CLS_JUMP;
            C_OP_JAL: dec.cls = CLS_JAL;
            default:  dec.cls = CLS_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mips_mc_ctrl                                                |
// | Brief    : Multi-cycle MIPS control FSM with retired-instruction count.|
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module mips_mc_ctrl
    import mips_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             dm_req,
    output logic             dm_we,
    output logic             alu_src_b,
    output logic [1:0]       ext_op,
    output logic [2:0]       alu_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [1:0]       npc_sel,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dec_t             w_dec;

    logic       w_pc_we, w_ir_we, w_reg_we, w_dm_req, w_dm_we, w_done;
    logic       w_alu_src_b;
    logic [1:0] w_ext_op, w_reg_dst, w_wd_sel, w_npc_sel;
    logic [2:0] w_alu_op;

    mips_mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (w_dec)
    );

    always_comb begin
        state_d     = ST_FETCH;
        w_pc_we     = 1'b0;
        w_ir_we     = 1'b0;
        w_reg_we    = 1'b0;
        w_dm_req    = 1'b0;
        w_dm_we     = 1'b0;
        w_done      = 1'b0;
        w_alu_src_b = 1'b0;
        w_ext_op    = C_EXT_ZERO;
        w_alu_op    = C_ALU_ADD;
        w_reg_dst   = C_RDST_RT;
        w_wd_sel    = C_WD_ALU;
        w_npc_sel   = C_NPC_PC4;
        case (state_q)
            ST_FETCH: begin
                w_ir_we   = 1'b1;
                w_pc_we   = 1'b1;
                w_npc_sel = C_NPC_PC4;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_dec.cls)
                    CLS_JUMP: begin
                        w_pc_we   = 1'b1;
                        w_npc_sel = C_NPC_JUMP;
                        w_done    = 1'b1;
                    end
                    CLS_JAL: begin
                        w_pc_we   = 1'b1;
                        w_npc_sel = C_NPC_JUMP;
                        w_reg_we  = 1'b1;
                        w_reg_dst = C_RDST_RA;
                        w_wd_sel  = C_WD_PC4;
                        w_done    = 1'b1;
                    end
                    CLS_JR: begin
                        w_pc_we   = 1'b1;
                        w_npc_sel = C_NPC_RS;
                        w_done    = 1'b1;
                    end
                    CLS_NOP: w_done  = 1'b1;
                    default: state_d = ST_EXECUTE;
                endcase
            end
            ST_EXECUTE: begin
                w_alu_op    = w_dec.alu_op;
                w_ext_op    = w_dec.ext_op;
                w_alu_src_b = w_dec.alu_src_b;
                case (w_dec.cls)
                    CLS_BRANCH: begin
                        w_pc_we   = zero;
                        w_npc_sel = C_NPC_BRANCH;
                        w_done    = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    default:             state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                w_dm_req = 1'b1;
                w_dm_we  = (w_dec.cls == CLS_STORE);
                if (!dm_ready) begin
                    state_d = ST_MEMORY;
                end else if (w_dec.cls == CLS_STORE) begin
                    w_done = 1'b1;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                w_reg_we = 1'b1;
                w_done   = 1'b1;
                case (w_dec.cls)
                    CLS_ALU_R: w_reg_dst = C_RDST_RD;
                    CLS_LOAD:  w_wd_sel  = C_WD_DM;
                    default:   w_reg_dst = C_RDST_RT;
                endcase
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are masked by reset directly so a bus request dies with reset, not a clock later.
    assign pc_we      = w_pc_we  & ~reset;
    assign ir_we      = w_ir_we  & ~reset;
    assign reg_we     = w_reg_we & ~reset;
    assign dm_req     = w_dm_req & ~reset;
    assign dm_we      = w_dm_we  & ~reset;
    assign instr_done = w_done   & ~reset;
    assign alu_src_b  = w_alu_src_b;
    assign ext_op     = w_ext_op;
    assign alu_op     = w_alu_op;
    assign reg_dst    = w_reg_dst;
    assign wd_sel     = w_wd_sel;
    assign npc_sel    = w_npc_sel;
    assign instr_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mips_mc_ctrl                                             |
// | Brief    : Scoreboard bench for the multi-cycle control FSM.           |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_mips_mc_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode, funct;
    logic             zero, dm_ready;
    logic             pc_we, ir_we, reg_we, dm_req, dm_we, alu_src_b, instr_done;
    logic [1:0]       ext_op, reg_dst, wd_sel, npc_sel;
    logic [2:0]       alu_op;
    logic [CNT_W-1:0] instr_cnt;

    mips_mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .dm_ready   (dm_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .npc_sel    (npc_sel),
        .instr_done (instr_done),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             pc_we, ir_we, reg_we, dm_req, dm_we, alu_src_b;
        logic [1:0]       ext_op;
        logic [2:0]       alu_op;
        logic [1:0]       reg_dst, wd_sel, npc_sel;
        logic             instr_done;
        logic [CNT_W-1:0] instr_cnt;
    } outs_t;

    outs_t            exp_q[$];
    string            tag_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [CNT_W-1:0] cnt_m    = '0;

    function automatic outs_t mk(input logic pc, ir, rg, rq, we, sb,
                                 input logic [1:0] ex, input logic [2:0] al,
                                 input logic [1:0] rd, wd, np, input logic dn);
        mk = {pc, ir, rg, rq, we, sb, ex, al, rd, wd, np, dn, cnt_m};
    endfunction

    function automatic outs_t z();
        z = mk(0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0);
    endfunction

    task automatic cyc(input string tag, input outs_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (e.instr_done) cnt_m = cnt_m + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        cyc("fetch", mk(1, 1, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0));
    endtask

    task automatic alu_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input outs_t ex_e,
                             input outs_t wb_e);
        fetch(op, fn);
        cyc({tag, "_dec"}, z());
        cyc({tag, "_ex"}, ex_e);
        cyc({tag, "_wb"}, wb_e);
    endtask

    task automatic nop_instr();
        fetch(6'h3F, 6'h00);
        cyc("nop_dec", mk(0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1));
    endtask

    // Monitor: every cycle that stimulus scheduled an expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outs_t act, e;
            string t;
            act = {pc_we, ir_we, reg_we, dm_req, dm_we, alu_src_b, ext_op, alu_op,
                   reg_dst, wd_sel, npc_sel, instr_done, instr_cnt};
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL %s: got %h expected %h", t, act, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d/%0d)", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        opcode   = 6'h00;
        funct    = 6'h00;
        zero     = 1'b0;
        dm_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc("reset", z());
        reset = 1'b0;

        alu_instr("addu", 6'h00, 6'h21,
                  z(),
                  mk(0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd1, 2'd0, 2'd0, 1));

        // lw with two wait cycles from data memory
        fetch(6'h23, 6'h00);
        cyc("lw_dec", z());
        cyc("lw_ex", mk(0, 0, 0, 0, 0, 1, 2'd1, 3'd0, 2'd0, 2'd0, 2'd0, 0));
        dm_ready = 1'b0;
        cyc("lw_mem_wait", mk(0, 0, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0));
        cyc("lw_mem_wait", mk(0, 0, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0));
        dm_ready = 1'b1;
        cyc("lw_mem_ack", mk(0, 0, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0));
        cyc("lw_wb", mk(0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd1, 2'd0, 1));

        fetch(6'h04, 6'h00);
        cyc("beq_dec", z());
        zero = 1'b1;
        cyc("beq_taken_ex", mk(1, 0, 0, 0, 0, 0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd1, 1));
        fetch(6'h04, 6'h00);
        cyc("beq_dec", z());
        zero = 1'b0;
        cyc("beq_nt_ex", mk(0, 0, 0, 0, 0, 0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd1, 1));

        fetch(6'h03, 6'h00);
        cyc("jal_dec", mk(1, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd2, 2'd2, 2'd2, 1));

        nop_instr();

        alu_instr("subu", 6'h00, 6'h23,
                  mk(0, 0, 0, 0, 0, 0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd0, 0),
                  mk(0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd1, 2'd0, 2'd0, 1));
        alu_instr("ori", 6'h0D, 6'h00,
                  mk(0, 0, 0, 0, 0, 1, 2'd0, 3'd2, 2'd0, 2'd0, 2'd0, 0),
                  mk(0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1));
        alu_instr("lui", 6'h0F, 6'h00,
                  mk(0, 0, 0, 0, 0, 1, 2'd2, 3'd3, 2'd0, 2'd0, 2'd0, 0),
                  mk(0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1));

        fetch(6'h2B, 6'h00);
        cyc("sw_dec", z());
        cyc("sw_ex", mk(0, 0, 0, 0, 0, 1, 2'd1, 3'd0, 2'd0, 2'd0, 2'd0, 0));
        cyc("sw_mem", mk(0, 0, 0, 1, 1, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1));

        fetch(6'h02, 6'h00);
        cyc("j_dec", mk(1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd2, 1));
        fetch(6'h00, 6'h08);
        cyc("jr_dec", mk(1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd3, 1));

        // Twelve retired so far; four more wrap the 4-bit counter back to zero.
        for (int i = 0; i < 4; i++) nop_instr();

        // sw stalled in MEMORY, then reset lands while the request is outstanding
        fetch(6'h2B, 6'h00);
        cyc("sw2_dec", z());
        cyc("sw2_ex", mk(0, 0, 0, 0, 0, 1, 2'd1, 3'd0, 2'd0, 2'd0, 2'd0, 0));
        dm_ready = 1'b0;
        cyc("sw2_mem_wait", mk(0, 0, 0, 1, 1, 0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0));
        reset = 1'b1;
        cnt_m = '0;
        cyc("rst_in_mem", z());
        cyc("rst_hold", z());
        reset    = 1'b0;
        dm_ready = 1'b1;
        nop_instr();
        fetch(6'h3F, 6'h00);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
